// File: rtl/lcd1602_pkg.sv
// lcd1602_pkg
//   Shared definitions for the LCD1602 parallel-bus controller and receiver:
//   the instruction bytes the controller issues, DDRAM window bases and AC
//   wrap points, the synchronized bus sample record and the receiver FSM states.
package lcd1602_pkg;

    // Instruction bytes used by the controller's init and cursor sequences.
    localparam logic [7:0] CLEAR_DISPLAY             = 8'h01;
    localparam logic [7:0] SHIFT_CURSOR_RIGHT        = 8'h06;
    localparam logic [7:0] DISPON_CURSOROFF          = 8'h0C;
    localparam logic [7:0] LINES2_MATRIX5x8_MODE8bit = 8'h38;
    localparam logic [7:0] START_2LINE               = 8'hC0;

    // DDRAM addressing: each line of a two-line panel spans 40 addresses; a
    // one-line panel spans 80 contiguous addresses.
    localparam logic [6:0] LINE1_BASE    = 7'h00;
    localparam logic [6:0] LINE2_BASE    = 7'h40;
    localparam logic [6:0] LINE1_LAST    = 7'h27;
    localparam logic [6:0] LINE2_LAST    = 7'h67;
    localparam logic [6:0] ONE_LINE_LAST = 7'h4F;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    // One sample of the bus pins.
    typedef struct packed {
        logic       e;
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } bus_sample_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_CLEAR
    } rx_state_e;

endpackage

// File: rtl/lcd1602_ac_step.sv
// lcd1602_ac_step
//   Next value of the DDRAM address counter after one step.
//   ac_i        current address counter
//   inc_i       1 = step up, 0 = step down
//   two_line_i  selects the two-line (0x00-0x27 / 0x40-0x67) or one-line
//               (0x00-0x4F) address map
//   ac_next_o   stepped address counter
module lcd1602_ac_step
    import lcd1602_pkg::*;
(
    input  logic [6:0] ac_i,
    input  logic       inc_i,
    input  logic       two_line_i,
    output logic [6:0] ac_next_o
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if-tree leaves it unassigned and infers a latch.
    always_comb begin
        ac_next_o = inc_i ? ac_i + 7'd1 : ac_i - 7'd1;
        if (two_line_i) begin
            // The end of one line continues at the start of the other.
            if (inc_i && ac_i == LINE1_LAST)       ac_next_o = LINE2_BASE;
            else if (inc_i && ac_i == LINE2_LAST)  ac_next_o = LINE1_BASE;
            else if (!inc_i && ac_i == LINE1_BASE) ac_next_o = LINE2_LAST;
            else if (!inc_i && ac_i == LINE2_BASE) ac_next_o = LINE1_LAST;
        end else begin
            if (inc_i && ac_i == ONE_LINE_LAST)    ac_next_o = LINE1_BASE;
            else if (!inc_i && ac_i == LINE1_BASE) ac_next_o = ONE_LINE_LAST;
        end
    end

endmodule

// File: rtl/lcd1602_bus_receiver.sv
// lcd1602_bus_receiver
//   LCD-side model of the HD44780 8-bit bus: samples each transfer on the
//   falling edge of enable, decodes it and keeps a shadow of the visible
//   2 x LINE_CHARS character window plus the display mode state.
//   Inputs : clk, reset (async, active low), lcd_e/lcd_rs/lcd_rw/lcd_data bus
//            pins, rd_addr shadow read index (0-15 line 1, 16-31 line 2).
//   Outputs: rd_data (registered read), char_valid/char_index/char_data per
//            stored character, cmd_valid/cmd_code per instruction,
//            addr_counter, display_on/entry_inc/mode_8bit/two_line mode bits,
//            busy during a clear, err_flags sticky error bits
//            ([0] unsupported op, [1] transfer while busy, [2] read transfer).
module lcd1602_bus_receiver
    import lcd1602_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LINE_CHARS  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       char_valid,
    output logic [4:0] char_index,
    output logic [7:0] char_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [6:0] addr_counter,
    output logic       display_on,
    output logic       entry_inc,
    output logic       mode_8bit,
    output logic       two_line,
    output logic       busy,
    output logic [2:0] err_flags
);

    localparam int DEPTH = 2 * LINE_CHARS;

    bus_sample_t [SYNC_STAGES-1:0] sync_q;
    bus_sample_t prev_q;
    rx_state_e   state_q;
    logic [4:0]  clr_idx_q;
    logic [6:0]  ac_q;
    logic        display_on_q, entry_inc_q, mode_8bit_q, two_line_q, busy_q;
    logic [2:0]  err_q;
    logic        char_valid_q, cmd_valid_q;
    logic [4:0]  char_index_q;
    logic [7:0]  char_data_q, cmd_code_q, rd_data_q;

    logic [7:0]  shadow_mem [DEPTH];

    bus_sample_t cur_s;
    logic        strobe;
    logic        win_hit;
    logic [4:0]  win_idx;
    logic [6:0]  ac_step_next;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [7:0]  mem_wdata;

    assign cur_s  = sync_q[SYNC_STAGES-1];
    // Falling edge of synchronized enable; the transfer is the pre-fall sample.
    assign strobe = prev_q.e & ~cur_s.e;

    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples its inputs from before the clock edge, regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0],
                       bus_sample_t'{e: lcd_e, rs: lcd_rs, rw: lcd_rw, data: lcd_data}};
            prev_q <= cur_s;
        end
    end

    // Data writes step per entry mode; cursor-move instructions by bit 2.
    lcd1602_ac_step u_ac_step (
        .ac_i       (ac_q),
        .inc_i      (prev_q.rs ? entry_inc_q : prev_q.data[2]),
        .two_line_i (two_line_q),
        .ac_next_o  (ac_step_next)
    );

    // Map AC onto the visible window of each line.
    always_comb begin
        win_hit = 1'b0;
        win_idx = 5'(ac_q);
        if (ac_q < 7'(LINE_CHARS)) begin
            win_hit = 1'b1;
        end else if (ac_q >= LINE2_BASE && ac_q < LINE2_BASE + 7'(LINE_CHARS)) begin
            win_hit = 1'b1;
            win_idx = 5'(LINE_CHARS) + 5'(ac_q - LINE2_BASE);
        end
    end

    // Single write port: CLEAR owns it; char writes only happen in IDLE.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = win_idx;
        mem_wdata = prev_q.data;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q;
            mem_wdata = BLANK_CHAR;
        end else if (state_q == ST_IDLE && strobe && !prev_q.rw && prev_q.rs && win_hit) begin
            mem_we = 1'b1;
        end
    end

    // NOTE: the shadow storage has no reset; its contents are only defined
    // after a clear, and leaving it unreset keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (mem_we) shadow_mem[mem_waddr] <= mem_wdata;
    end

    // Read-before-write: a same-index write this cycle returns the old byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data_q <= '0;
        else        rd_data_q <= shadow_mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            clr_idx_q    <= '0;
            ac_q         <= '0;
            display_on_q <= 1'b0;
            entry_inc_q  <= 1'b1;
            mode_8bit_q  <= 1'b1;
            two_line_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= '0;
            char_valid_q <= 1'b0;
            char_index_q <= '0;
            char_data_q  <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= '0;
        end else begin
            char_valid_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (strobe) begin
                        state_q <= ST_DECODE;
                        if (prev_q.rw) begin
                            err_q[2] <= 1'b1;
                        end else if (prev_q.rs) begin
                            char_valid_q <= win_hit;
                            char_index_q <= win_idx;
                            char_data_q  <= prev_q.data;
                            ac_q         <= ac_step_next;
                        end else begin
                            cmd_valid_q <= 1'b1;
                            cmd_code_q  <= prev_q.data;
                            // Decoded by the highest set bit.
                            casez (prev_q.data)
                                8'b1???_????: ac_q <= prev_q.data[6:0];
                                8'b01??_????: err_q[0] <= 1'b1;
                                8'b001?_????: begin
                                    mode_8bit_q <= prev_q.data[4];
                                    two_line_q  <= prev_q.data[3];
                                    if (!prev_q.data[4]) err_q[0] <= 1'b1;
                                end
                                8'b0001_????: begin
                                    if (prev_q.data[3]) err_q[0] <= 1'b1;
                                    else                ac_q <= ac_step_next;
                                end
                                8'b0000_1???: display_on_q <= prev_q.data[2];
                                8'b0000_01??: begin
                                    entry_inc_q <= prev_q.data[1];
                                    if (prev_q.data[0]) err_q[0] <= 1'b1;
                                end
                                8'b0000_001?: ac_q <= '0;
                                8'b0000_0001: begin
                                    ac_q        <= '0;
                                    entry_inc_q <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_DECODE: begin
                    // cmd_valid_q/cmd_code_q still hold the instruction just decoded.
                    if (cmd_valid_q && cmd_code_q == CLEAR_DISPLAY) begin
                        state_q   <= ST_CLEAR;
                        busy_q    <= 1'b1;
                        clr_idx_q <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (strobe) err_q[1] <= 1'b1;
                    if (clr_idx_q == 5'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_idx_q <= clr_idx_q + 5'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_data      = rd_data_q;
    assign char_valid   = char_valid_q;
    assign char_index   = char_index_q;
    assign char_data    = char_data_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_code     = cmd_code_q;
    assign addr_counter = ac_q;
    assign display_on   = display_on_q;
    assign entry_inc    = entry_inc_q;
    assign mode_8bit    = mode_8bit_q;
    assign two_line     = two_line_q;
    assign busy         = busy_q;
    assign err_flags    = err_q;

endmodule

// File: tb/tb_lcd1602_bus_receiver.sv
// tb_lcd1602_bus_receiver
//   Drives HD44780 bus transfers into lcd1602_bus_receiver and compares its
//   outputs against a behavioural LCD model kept in this file.
module tb_lcd1602_bus_receiver;
    import lcd1602_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data, char_data, cmd_code;
    logic       char_valid, cmd_valid, display_on, entry_inc, mode_8bit, two_line, busy;
    logic [4:0] char_index;
    logic [6:0] addr_counter;
    logic [2:0] err_flags;

    always #5 clk = ~clk;

    lcd1602_bus_receiver #(.SYNC_STAGES(2), .LINE_CHARS(16)) dut (
        .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .char_valid(char_valid), .char_index(char_index), .char_data(char_data),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .addr_counter(addr_counter),
        .display_on(display_on), .entry_inc(entry_inc), .mode_8bit(mode_8bit),
        .two_line(two_line), .busy(busy), .err_flags(err_flags)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: pulses are counted away from the active edge.
    int         char_cnt = 0, cmd_cnt = 0, busy_cnt = 0;
    logic [4:0] last_idx = '0;
    logic [7:0] last_char = '0, last_cmd = '0;
    always @(negedge clk) begin
        if (char_valid) begin char_cnt++; last_idx = char_index; last_char = char_data; end
        if (cmd_valid)  begin cmd_cnt++;  last_cmd = cmd_code; end
        if (busy)       busy_cnt++;
    end

    // Behavioural LCD model.
    int         m_ac;
    bit         m_inc, m_don, m_8bit, m_two, m_busy;
    logic [2:0] m_err;
    logic [7:0] m_shadow [32];

    task automatic model_reset();
        m_ac = 0; m_inc = 1; m_don = 0; m_8bit = 1; m_two = 0; m_busy = 0; m_err = 3'b000;
    endtask

    // Address stepping via a linear cursor position over the 80 DDRAM cells.
    function automatic int model_step(input int ac, input bit inc);
        int pos;
        pos = (m_two && ac >= 64) ? ac - 64 + 40 : ac;
        pos = inc ? (pos + 1) % 80 : (pos + 79) % 80;
        return (m_two && pos >= 40) ? pos - 40 + 64 : pos;
    endfunction

    task automatic model_apply(input bit rs, input bit rw, input logic [7:0] d,
                               output bit e_char, output bit e_cmd, output int e_idx);
        e_char = 0; e_cmd = 0; e_idx = 0;
        if (m_busy) begin m_err[1] = 1'b1; return; end
        if (rw)     begin m_err[2] = 1'b1; return; end
        if (rs) begin
            if (m_ac < 16)                   begin e_char = 1; e_idx = m_ac; end
            else if (m_ac >= 64 && m_ac < 80) begin e_char = 1; e_idx = m_ac - 64 + 16; end
            if (e_char) m_shadow[e_idx] = d;
            m_ac = model_step(m_ac, m_inc);
        end else begin
            e_cmd = 1;
            if (d >= 128)     m_ac = int'(d) - 128;
            else if (d >= 64) m_err[0] = 1'b1;
            else if (d >= 32) begin
                m_8bit = d[4]; m_two = d[3];
                if (!d[4]) m_err[0] = 1'b1;
            end else if (d >= 16) begin
                if (d[3]) m_err[0] = 1'b1;
                else      m_ac = model_step(m_ac, d[2]);
            end else if (d >= 8) m_don = d[2];
            else if (d >= 4) begin
                m_inc = d[1];
                if (d[0]) m_err[0] = 1'b1;
            end else if (d >= 2) m_ac = 0;
            else if (d == 1) begin
                m_ac = 0; m_inc = 1; m_busy = 1;
                for (int i = 0; i < 32; i++) m_shadow[i] = BLANK_CHAR;
            end
        end
    endtask

    task automatic drive_strobe(input bit rs, input bit rw, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        lcd_e = 1'b0;
    endtask

    // One bus transfer, checked against the model once its decode has landed.
    task automatic xfer(input bit rs, input bit rw, input logic [7:0] d,
                        output bit got_char, output int got_idx);
        int c0, k0, e_idx;
        bit e_char, e_cmd;
        c0 = char_cnt; k0 = cmd_cnt;
        model_apply(rs, rw, d, e_char, e_cmd, e_idx);
        drive_strobe(rs, rw, d);
        repeat (6) @(negedge clk);
        got_char = (char_cnt != c0);
        got_idx  = got_char ? int'(last_idx) : 99;
        check("char_pulses", char_cnt - c0, e_char);
        if (e_char) begin
            check("char_index", last_idx, e_idx);
            check("char_data", last_char, d);
        end
        check("cmd_pulses", cmd_cnt - k0, e_cmd);
        if (e_cmd) check("cmd_code", last_cmd, d);
        check("ac", addr_counter, m_ac);
        check("mode_bits", {display_on, entry_inc, mode_8bit, two_line}, {m_don, m_inc, m_8bit, m_two});
        check("err_flags", err_flags, m_err);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("busy_released", busy, 0);
        m_busy = 0;
    endtask

    task automatic read_at(input int a, output logic [7:0] v);
        @(negedge clk);
        rd_addr = 5'(a);
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic read_all(input string name);
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            read_at(i, v);
            check(name, v, m_shadow[i]);
        end
    endtask

    typedef struct {
        bit         rs;
        logic [7:0] d;
        logic [6:0] exp_ac;
        int         exp_idx;   // 99 = no character stored
    } vec_t;

    vec_t  tbl[24];
    string line1 = "LATITUD:        ";
    string line2 = "LONGITUD:       ";

    initial begin
        bit         gc;
        int         gi, n;
        logic [7:0] v, d;

        tbl = '{
            '{1'b0, 8'h84, 7'h04, 99}, '{1'b1, 8'h31, 7'h05, 4},  '{1'b1, 8'h32, 7'h06, 5},
            '{1'b1, 8'h38, 7'h07, 6},  '{1'b0, 8'hA7, 7'h27, 99}, '{1'b1, 8'h41, 7'h40, 99},
            '{1'b0, 8'h04, 7'h40, 99}, '{1'b0, 8'h80, 7'h00, 99}, '{1'b1, 8'h42, 7'h67, 0},
            '{1'b0, 8'h06, 7'h67, 99}, '{1'b1, 8'h45, 7'h00, 16'd99}, '{1'b0, 8'hC0, 7'h40, 99},
            '{1'b0, 8'h10, 7'h27, 99}, '{1'b0, 8'h14, 7'h40, 99}, '{1'b0, 8'hCF, 7'h4F, 99},
            '{1'b0, 8'h30, 7'h4F, 99}, '{1'b1, 8'h43, 7'h00, 31}, '{1'b0, 8'h04, 7'h00, 99},
            '{1'b1, 8'h44, 7'h4F, 0},  '{1'b0, 8'h10, 7'h4E, 99}, '{1'b0, 8'h14, 7'h4F, 99},
            '{1'b0, 8'h38, 7'h4F, 99}, '{1'b0, 8'h06, 7'h4F, 99}, '{1'b0, 8'h84, 7'h04, 99}
        };

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ac", addr_counter, 0);
        check("rst_mode", {display_on, entry_inc, mode_8bit, two_line}, 4'b0110);
        check("rst_busy", busy, 0);
        check("rst_err", err_flags, 0);
        check("rst_pulses", {char_valid, cmd_valid}, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b1;
        model_reset();

        // Controller init sequence.
        busy_cnt = 0;
        xfer(1'b0, 1'b0, LINES2_MATRIX5x8_MODE8bit, gc, gi);
        xfer(1'b0, 1'b0, SHIFT_CURSOR_RIGHT, gc, gi);
        xfer(1'b0, 1'b0, DISPON_CURSOROFF, gc, gi);
        xfer(1'b0, 1'b0, CLEAR_DISPLAY, gc, gi);
        wait_idle();
        check("busy_cycles", busy_cnt, 32);
        check("cmds_after_init", cmd_cnt, 4);
        check("init_mode", {display_on, entry_inc, mode_8bit, two_line}, 4'b1111);
        read_all("clear_fill");

        // Two full visible lines.
        for (int i = 0; i < 16; i++) xfer(1'b1, 1'b0, line1[i], gc, gi);
        xfer(1'b0, 1'b0, START_2LINE, gc, gi);
        for (int i = 0; i < 16; i++) xfer(1'b1, 1'b0, line2[i], gc, gi);
        check("ac_after_lines", addr_counter, 7'h50);
        read_all("lines");

        // Addressing and wrap vectors.
        foreach (tbl[i]) begin
            xfer(tbl[i].rs, 1'b0, tbl[i].d, gc, gi);
            check("tbl_ac", addr_counter, tbl[i].exp_ac);
            check("tbl_char", gi, tbl[i].exp_idx);
        end
        read_at(4, v); check("shadow4", v, 8'h31);
        read_at(5, v); check("shadow5", v, 8'h32);
        read_at(6, v); check("shadow6", v, 8'h38);
        read_all("after_table");

        // Transfer dropped during a clear, then a read transfer.
        xfer(1'b0, 1'b0, CLEAR_DISPLAY, gc, gi);
        check("busy_in_clear", busy, 1);
        xfer(1'b1, 1'b0, 8'h5A, gc, gi);
        wait_idle();
        xfer(1'b0, 1'b1, 8'h33, gc, gi);
        check("err_110", err_flags, 3'b110);
        read_all("after_drop");

        // Reset at the 10th clear cycle.
        drive_strobe(1'b0, 1'b0, CLEAR_DISPLAY);
        n = 0;
        while (busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("busy_seen", busy, 1);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ac", addr_counter, 0);
        check("rst_mid_mode", {display_on, entry_inc, mode_8bit, two_line}, 4'b0110);
        check("rst_mid_err", err_flags, 0);
        reset = 1'b1;
        model_reset();
        busy_cnt = 0;
        xfer(1'b0, 1'b0, LINES2_MATRIX5x8_MODE8bit, gc, gi);
        xfer(1'b0, 1'b0, SHIFT_CURSOR_RIGHT, gc, gi);
        xfer(1'b0, 1'b0, DISPON_CURSOROFF, gc, gi);
        xfer(1'b0, 1'b0, CLEAR_DISPLAY, gc, gi);
        wait_idle();
        check("busy_cycles_reinit", busy_cnt, 32);

        // Random traffic in two-line mode.
        for (int k = 0; k < 150; k++) begin
            int r, pos;
            r = $urandom_range(0, 19);
            case (r)
                9, 10: begin
                    pos = $urandom_range(0, 79);
                    d = 8'h80 | 8'(pos < 40 ? pos : pos - 40 + 64);
                    xfer(1'b0, 1'b0, d, gc, gi);
                end
                11: xfer(1'b0, 1'b0, 8'h04 | 8'($urandom_range(0, 3)), gc, gi);
                12: xfer(1'b0, 1'b0, 8'h08 | 8'($urandom_range(0, 7)), gc, gi);
                13: xfer(1'b0, 1'b0, 8'h10 | 8'($urandom_range(0, 15)), gc, gi);
                14: xfer(1'b0, 1'b0, 8'h28 | 8'($urandom_range(0, 1) << 4) | 8'($urandom_range(0, 3)), gc, gi);
                15: xfer(1'b0, 1'b0, 8'h40 | 8'($urandom_range(0, 63)), gc, gi);
                16: xfer(1'b0, 1'b0, 8'h02 | 8'($urandom_range(0, 1)), gc, gi);
                17: xfer(1'($urandom_range(0, 1)), 1'b1, 8'($urandom_range(0, 255)), gc, gi);
                18: begin
                    xfer(1'b0, 1'b0, CLEAR_DISPLAY, gc, gi);
                    wait_idle();
                end
                default: xfer(1'b1, 1'b0, 8'($urandom_range(0, 255)), gc, gi);
            endcase
        end
        read_all("random_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
